// File: rtl/delta_sigma_pkg.sv
// Shared definitions for the delta-sigma DAC: default widths, integrator
// width growth, loop mode encoding, feedback value and saturation limits.
package delta_sigma_pkg;

  localparam int DEF_BW    = 16;  // signed sample width
  localparam int DEF_OSR_W = 8;   // width of the oversampling-period input
  localparam int I1_EXTRA  = 2;   // first integrator is BW+2 bits wide
  localparam int I2_EXTRA  = 4;   // second integrator is BW+4 bits wide

  typedef enum logic {
    MODE_FIRST  = 1'b0,
    MODE_SECOND = 1'b1
  } mode_e;

  // Feedback applied by the 1-bit quantiser: +2^(bw-1) for a one, -2^(bw-1) for a zero.
  function automatic longint fb_value(input int bw, input logic dac);
    longint mag;
    mag = longint'(1) <<< (bw - 1);
    return dac ? mag : -mag;
  endfunction

  // Two's-complement limits of a w-bit signed accumulator.
  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/delta_sigma_integ.sv
// Saturating signed accumulator used for both loop integrators.
// Ports:
//   clk        - clock, state on rising edge
//   rst        - synchronous active-high reset, clears the accumulator
//   clr        - synchronous clear (loop disabled / integrator unused)
//   en         - update enable
//   delta      - signed increment added this cycle
//   value_next - saturated next value (acc + delta), combinational
module delta_sigma_integ
  import delta_sigma_pkg::*;
#(
  parameter int W = DEF_BW + I1_EXTRA
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic signed [W-1:0] delta,
  output logic signed [W-1:0] value_next
);

  localparam logic signed [W-1:0] MAX_V = W'(sat_max(W));
  localparam logic signed [W-1:0] MIN_V = W'(sat_min(W));

  logic signed [W-1:0] acc;
  logic signed [W:0]   sum;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    sum = {acc[W-1], acc} + {delta[W-1], delta};
    // The two top bits differ only when the true sum left the W-bit range;
    // the extra bit then carries the real sign and picks the clamp.
    if (sum[W] != sum[W-1]) value_next = sum[W] ? MIN_V : MAX_V;
    else                    value_next = sum[W-1:0];
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) acc <= '0;
    else if (en)    acc <= value_next;
  end

endmodule

// File: rtl/delta_sigma_dac2.sv
// First/second-order 1-bit delta-sigma DAC with a one-deep input holding
// register and a programmable sample period.
// Ports:
//   clk_i         - clock
//   rst_i         - synchronous active-high reset
//   en_i          - modulator enable; low clears the loop and period counter
//   mode_i        - 0 first-order, 1 second-order; captured only while en_i=0
//   osr_i         - sample period in clocks minus 1
//   din_i         - signed sample offered to the holding register
//   din_valid_i   - din_i is valid
//   din_ready_o   - holding register is empty
//   dac_o         - registered modulator bit
//   sample_tick_o - pulse: a sample period started (new or repeated sample)
//   underrun_o    - pulse: the period started with the holding register empty
module delta_sigma_dac2
  import delta_sigma_pkg::*;
#(
  parameter int BW    = DEF_BW,
  parameter int OSR_W = DEF_OSR_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 mode_i,
  input  logic [OSR_W-1:0]     osr_i,
  input  logic signed [BW-1:0] din_i,
  input  logic                 din_valid_i,
  output logic                 din_ready_o,
  output logic                 dac_o,
  output logic                 sample_tick_o,
  output logic                 underrun_o
);

  localparam int I1_W = BW + I1_EXTRA;
  localparam int I2_W = BW + I2_EXTRA;

  logic signed [BW-1:0]   hold_q;
  logic                   hold_valid;
  logic signed [BW-1:0]   x_q;
  logic [OSR_W-1:0]       cnt_q;
  mode_e                  mode_q;
  logic                   dac_q;
  logic                   tick_q;
  logic                   underrun_q;

  logic                   accept;
  logic                   tick;
  logic signed [I1_W-1:0] delta1;
  logic signed [I2_W-1:0] delta2;
  logic signed [I1_W-1:0] i1_next;
  logic signed [I2_W-1:0] i2_next;

  // Accepting needs an empty holding register, so an accept on a tick cycle
  // always sees the tick as an underrun; the new sample waits a full period.
  assign accept = din_valid_i && !hold_valid;
  assign tick   = en_i && (cnt_q == '0);

  assign delta1 = I1_W'(x_q)     - I1_W'(fb_value(BW, dac_q));
  assign delta2 = I2_W'(i1_next) - I2_W'(fb_value(BW, dac_q));

  delta_sigma_integ #(.W(I1_W)) u_integ1 (
    .clk        (clk_i),
    .rst        (rst_i),
    .clr        (!en_i),
    .en         (en_i),
    .delta      (delta1),
    .value_next (i1_next)
  );

  delta_sigma_integ #(.W(I2_W)) u_integ2 (
    .clk        (clk_i),
    .rst        (rst_i),
    .clr        (!en_i || (mode_q == MODE_FIRST)),
    .en         (en_i),
    .delta      (delta2),
    .value_next (i2_next)
  );

  // NOTE: reset is sampled on the clock edge (synchronous); the asynchronous style is not used here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q     <= '0;
      hold_valid <= 1'b0;
      x_q        <= '0;
      cnt_q      <= '0;
      mode_q     <= MODE_FIRST;
      dac_q      <= 1'b0;
      tick_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      tick_q     <= tick;
      underrun_q <= tick && !hold_valid;

      if (!en_i) begin
        cnt_q  <= '0;
        mode_q <= mode_e'(mode_i);
        dac_q  <= 1'b0;
      end else begin
        cnt_q <= tick ? osr_i : cnt_q - OSR_W'(1);
        dac_q <= (mode_q == MODE_SECOND) ? !i2_next[I2_W-1] : !i1_next[I1_W-1];
      end

      if (tick && hold_valid) begin
        x_q        <= hold_q;
        hold_valid <= 1'b0;
      end else if (accept) begin
        hold_q     <= din_i;
        hold_valid <= 1'b1;
      end
    end
  end

  assign din_ready_o   = !hold_valid;
  assign dac_o         = dac_q;
  assign sample_tick_o = tick_q;
  assign underrun_o    = underrun_q;

endmodule

// File: tb/tb_delta_sigma_dac2.sv
module tb_delta_sigma_dac2;

  logic               clk = 1'b0;
  logic               rst_i;
  logic               en_i;
  logic               mode_i;
  logic [7:0]         osr_i;
  logic signed [15:0] din_i;
  logic               din_valid_i;
  logic               din_ready_o;
  logic               dac_o;
  logic               sample_tick_o;
  logic               underrun_o;

  int n_checks = 0;
  int n_fail   = 0;

  delta_sigma_dac2 #(.BW(16), .OSR_W(8)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .en_i          (en_i),
    .mode_i        (mode_i),
    .osr_i         (osr_i),
    .din_i         (din_i),
    .din_valid_i   (din_valid_i),
    .din_ready_o   (din_ready_o),
    .dac_o         (dac_o),
    .sample_tick_o (sample_tick_o),
    .underrun_o    (underrun_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic en;
    logic valid;
    logic exp_ready;
    logic exp_tick;
    logic exp_under;
  } hs_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic count_ones(input int n, output int ones);
    ones = 0;
    repeat (n) begin
      step();
      ones += int'(dac_o);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  // Pushes x through the holding register into the active sample, ends disabled.
  task automatic load_sample(input logic signed [15:0] x);
    en_i        = 1'b1;
    osr_i       = 8'd0;
    din_i       = x;
    din_valid_i = 1'b1;
    step();
    din_valid_i = 1'b0;
    step();
    en_i = 1'b0;
    step();
  endtask

  // Enables with the requested mode captured first.
  task automatic restart(input logic mode);
    en_i   = 1'b0;
    mode_i = mode;
    step();
    en_i = 1'b1;
  endtask

  hs_vec_t hs[19];
  logic    exp_m0[6];
  logic    exp_m1[12];

  initial begin
    int ones;
    int reps;
    logic prev;

    // Handshake/tick table with din_valid held, osr_i=3.
    hs[0]  = '{1, 1, 0, 1, 1};  // accept coincides with tick on empty holding
    hs[1]  = '{1, 1, 0, 0, 0};
    hs[2]  = '{1, 1, 0, 0, 0};
    hs[3]  = '{1, 1, 0, 0, 0};
    hs[4]  = '{1, 1, 1, 1, 0};  // tick loads the held sample
    hs[5]  = '{1, 1, 0, 0, 0};  // next accept
    hs[6]  = '{1, 1, 0, 0, 0};
    hs[7]  = '{1, 1, 0, 0, 0};
    hs[8]  = '{1, 1, 1, 1, 0};
    hs[9]  = '{1, 1, 0, 0, 0};
    hs[10] = '{1, 0, 0, 0, 0};
    hs[11] = '{1, 0, 0, 0, 0};
    hs[12] = '{1, 0, 1, 1, 0};
    hs[13] = '{1, 0, 1, 0, 0};
    hs[14] = '{1, 0, 1, 0, 0};
    hs[15] = '{1, 0, 1, 0, 0};
    hs[16] = '{1, 0, 1, 1, 1};  // nothing offered: underrun
    hs[17] = '{0, 0, 1, 0, 0};  // disabled: no tick
    hs[18] = '{1, 0, 1, 1, 1};  // counter was cleared: immediate tick
    exp_m0 = '{1, 1, 0, 1, 0, 1};
    exp_m1 = '{1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 1, 1};

    en_i = 1'b0; mode_i = 1'b0; osr_i = 8'd0; din_i = '0; din_valid_i = 1'b0;
    do_reset();
    check("reset dac", dac_o, 0);
    check("reset ready", din_ready_o, 1);
    check("reset tick", sample_tick_o, 0);
    check("reset underrun", underrun_o, 0);

    // x=0 first-order: 1,1 then alternating.
    restart(1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("m0 x=0 dac[%0d]", i), dac_o, exp_m0[i]);
    end
    restart(1'b0);
    count_ones(1024, ones);
    check_range("m0 x=0 ones/1024", ones, 511, 513);

    // Mode change while enabled must be ignored: alternation continues.
    restart(1'b0);
    repeat (4) step();
    mode_i = 1'b1;
    prev = dac_o;
    reps = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (dac_o == prev) reps++;
      prev = dac_o;
    end
    check("mode ignored while enabled repeats", reps, 0);

    // x=0 second-order, hand-traced sequence.
    restart(1'b1);
    for (int i = 0; i < 12; i++) begin
      step();
      check($sformatf("m1 x=0 dac[%0d]", i), dac_o, exp_m1[i]);
    end

    // x=16384 -> 3/4 ones density in both modes.
    load_sample(16'sd16384);
    restart(1'b0);
    repeat (16) step();
    count_ones(1024, ones);
    check_range("m0 x=16384 ones/1024", ones, 766, 770);
    restart(1'b1);
    repeat (16) step();
    count_ones(1024, ones);
    check_range("m1 x=16384 ones/1024", ones, 764, 772);

    // Full-scale negative: output stays 0; in mode 1 i2 must clamp, not wrap.
    load_sample(-16'sd32768);
    restart(1'b0);
    repeat (4) step();
    count_ones(256, ones);
    check("m0 x=-32768 ones", ones, 0);
    restart(1'b1);
    repeat (4) step();
    count_ones(200, ones);
    check("m1 x=-32768 ones (i2 saturated)", ones, 0);

    // Full-scale positive: at most one zero.
    load_sample(16'sd32767);
    restart(1'b0);
    repeat (4) step();
    count_ones(4096, ones);
    check_range("m0 x=32767 zeros/4096", 4096 - ones, 0, 1);

    // osr_i=3 with nothing offered: tick+underrun every 4th enabled cycle.
    do_reset();
    osr_i = 8'd3;
    restart(1'b0);
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("idle tick[%0d]", k), sample_tick_o, (k % 4 == 1));
      check($sformatf("idle underrun[%0d]", k), underrun_o, (k % 4 == 1));
    end

    // Handshake table.
    do_reset();
    en_i = 1'b0;
    step();
    din_i = 16'sd1000;
    for (int i = 0; i < 19; i++) begin
      en_i        = hs[i].en;
      din_valid_i = hs[i].valid;
      step();
      check($sformatf("hs ready[%0d]", i), din_ready_o, hs[i].exp_ready);
      check($sformatf("hs tick[%0d]", i), sample_tick_o, hs[i].exp_tick);
      check($sformatf("hs underrun[%0d]", i), underrun_o, hs[i].exp_under);
    end

    // Mid-period reset with the holding register full.
    do_reset();
    en_i = 1'b0; mode_i = 1'b0; din_valid_i = 1'b0;
    step();
    en_i = 1'b1; din_valid_i = 1'b1; din_i = 16'sd500;
    step();
    din_valid_i = 1'b0;
    check("pre-reset dac", dac_o, 1);
    check("pre-reset ready", din_ready_o, 0);
    step();
    rst_i = 1'b1;
    step();
    check("mid reset dac", dac_o, 0);
    check("mid reset ready", din_ready_o, 1);
    check("mid reset tick", sample_tick_o, 0);
    check("mid reset underrun", underrun_o, 0);
    rst_i = 1'b0;
    step();
    check("post reset tick", sample_tick_o, 1);
    check("post reset underrun", underrun_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/delta_sigma_dac2.md
DELTA_SIGMA_DAC2 -- requirements
Module: delta_sigma_dac2

Interface
REQ-001 SHALL have parameter BW, default 16: signed sample width.
REQ-002 SHALL have parameter OSR_W, default 8: width of oversampling-period input.
REQ-003 SHALL have port clk_i  in  1: single clock; all state on rising edge.
REQ-004 SHALL have port rst_i  in  1: reset, synchronous, active-high.
REQ-005 SHALL have port en_i  in  1: modulator enable.
REQ-006 SHALL have port mode_i  in  1: 0 = first-order, 1 = second-order loop.
REQ-007 SHALL have port osr_i  in  OSR_W: sample period in clocks minus 1.
REQ-008 SHALL have port din_i  in  BW: signed two's-complement sample.
REQ-009 SHALL have port din_valid_i  in  1: sample offered.
REQ-010 SHALL have port din_ready_o  out  1: holding register empty.
REQ-011 SHALL have port dac_o  out  1: registered 1-bit modulator output.
REQ-012 SHALL have port sample_tick_o  out  1: one-cycle pulse when a new active sample is loaded.
REQ-013 SHALL have port underrun_o  out  1: one-cycle pulse when a tick finds the holding register empty.

Function
REQ-014 SHALL accept din_i into the holding register on a cycle with din_valid_i && din_ready_o; din_ready_o low the next cycle.
REQ-015 SHALL hold din_ready_o low while the holding register is full; din_valid_i ignored then.
REQ-016 SHALL run period counter only while en_i=1: tick when counter==0, then reload osr_i; else decrement.
REQ-017 SHALL, on tick with holding full, copy it to the active sample, free holding (din_ready_o=1 next cycle), pulse sample_tick_o.
REQ-018 SHALL, on tick with holding empty, keep previous active sample and pulse both sample_tick_o and underrun_o.
REQ-019 SHALL, on a cycle with tick and accept together, treat holding as empty for the tick (underrun); accepted sample waits for next tick.
REQ-020 SHALL define FB = +2^(BW-1) when dac_o=1, -2^(BW-1) when dac_o=0, using current registered dac_o.
REQ-021 SHALL, every enabled cycle, update i1 <= sat(i1 + x - FB), x = active sample, i1 width BW+2.
REQ-022 SHALL, in second-order mode, also update i2 <= sat(i2 + i1_next - FB), i2 width BW+4; i2 held at 0 in first-order mode.
REQ-023 SHALL set dac_o <= (selected integrator next value >= 0): i1_next in first order, i2_next in second order.
REQ-024 SHALL saturate integrators at their signed min/max, never wrap.
REQ-025 SHALL, while en_i=0, force i1, i2, dac_o, counter to 0 and suppress ticks; holding register and handshake remain active.
REQ-026 SHALL sample mode_i only while en_i=0; mode change while enabled is ignored until next disable.
REQ-027 SHALL produce mean ones-density (x + 2^(BW-1)) / 2^BW for constant x in both modes.

Reset
REQ-028 SHALL, with rst_i=1 at a clock edge, clear i1, i2, active sample, holding valid, counter, stored mode (first-order) to 0.
REQ-029 SHALL present after reset: dac_o=0, din_ready_o=1, sample_tick_o=0, underrun_o=0.
REQ-030 SHALL abort any in-progress sample period on mid-operation reset; no tick or accept on the reset cycle.

Structure
REQ-031 SHALL place in package delta_sigma_pkg: default BW, integrator width offsets (2, 4), FB magnitude and saturation-limit constants/functions.
REQ-032 SHALL implement each integrator as one instance of sub-module delta_sigma_integ (parametrised-width saturating accumulator with clear and enable).
REQ-033 SHALL be synthesizable, single clock domain, no latches.

Verification
REQ-034 SHALL test: BW=16, mode 0, x=0, osr_i=0 -> after 2 cycles dac_o alternates 1,0; ones in 1024 cycles = 512 +/- 1.
REQ-035 SHALL test: x=16384, mode 0 then mode 1 (via en_i toggle) -> ones in 1024 cycles = 768 +/- 2 (mode 0), +/- 4 (mode 1).
REQ-036 SHALL test: x=-32768 -> dac_o stays 0; x=32767 -> at most 1 zero per 65536 cycles; no integrator wrap.
REQ-037 SHALL test: osr_i=3, no din_valid_i -> sample_tick_o and underrun_o pulse every 4th enabled cycle.
REQ-038 SHALL test: din_valid_i held high, osr_i=3 -> one accept per tick, din_ready_o low between; simultaneous tick+accept on empty holding gives underrun.
REQ-039 SHALL test: rst_i asserted mid-period with holding full -> next cycle all outputs at reset values, din_ready_o=1.
